// File: rtl/rd_id_tracker_pkg.sv
// rd_id_tracker_pkg
//   Shared types and sizing for the destination-register tracker.
//   id_t                : instruction ID carried through issue/commit
//   COMMIT_PORTS        : commit ports examined per cycle (port 0 = ALU)
//   REGFILE_READ_PORTS  : source operand lookups per cycle
//   rd_tracker_state_t  : clear-sweep FSM states
//   rd_writable()       : true for any architectural register other than x0
package rd_id_tracker_pkg;

  localparam int ID_W               = 3;
  localparam int COMMIT_PORTS       = 2;
  localparam int REGFILE_READ_PORTS = 2;

  typedef logic [ID_W-1:0] id_t;

  typedef enum logic {
    RT_CLEAR,
    RT_IDLE
  } rd_tracker_state_t;

  function automatic logic rd_writable(input logic [4:0] addr);
    return addr != 5'd0;
  endfunction

endpackage

// File: rtl/rd_id_tracker_if.sv
// rd_id_tracker_if
//   Bundles the issue, source-lookup, commit and trace signals of the tracker.
//   master : issue/decode/commit side (drives requests, receives lookups)
//   slave  : the tracker itself
//   gc_flush, issue_*          : master -> slave
//   rs_addr                    : master -> slave, source registers being decoded
//   retired, retired_rd_addr,
//   ids_retiring               : master -> slave, commit port activity
//   busy, rs_inuse, rs_id,
//   id_for_rd,
//   tr_rs_both_pending         : slave -> master
interface rd_id_tracker_if;
  import rd_id_tracker_pkg::*;

  logic                                gc_flush;
  logic                                busy;
  logic                                issue_valid;
  logic                                issue_uses_rd;
  logic [4:0]                          issue_rd_addr;
  id_t                                 issue_id;
  logic [REGFILE_READ_PORTS-1:0][4:0]  rs_addr;
  logic [REGFILE_READ_PORTS-1:0]       rs_inuse;
  id_t  [REGFILE_READ_PORTS-1:0]       rs_id;
  logic [COMMIT_PORTS-1:0]             retired;
  logic [COMMIT_PORTS-1:0][4:0]        retired_rd_addr;
  id_t  [COMMIT_PORTS-1:0]             ids_retiring;
  id_t  [COMMIT_PORTS-1:0]             id_for_rd;
  logic                                tr_rs_both_pending;

  modport master (
    output gc_flush, issue_valid, issue_uses_rd, issue_rd_addr, issue_id,
           rs_addr, retired, retired_rd_addr, ids_retiring,
    input  busy, rs_inuse, rs_id, id_for_rd, tr_rs_both_pending
  );

  modport slave (
    input  gc_flush, issue_valid, issue_uses_rd, issue_rd_addr, issue_id,
           rs_addr, retired, retired_rd_addr, ids_retiring,
    output busy, rs_inuse, rs_id, id_for_rd, tr_rs_both_pending
  );

endinterface

// File: rtl/rd_id_tracker.sv
// rd_id_tracker
//   Records, per architectural register, the ID of the newest issued writer
//   (id_table) and whether that writer is still outstanding (pending).
//   Writeback uses id_for_rd to commit only the newest write; decode uses
//   rs_inuse/rs_id for hazard detection. Reset or gc_flush start a 32-cycle
//   sweep that clears pending one entry per cycle, so neither table needs a
//   bulk reset and id_table stays LUTRAM-friendly.
// Ports
//   clk  : clock
//   rst  : synchronous, active-high reset
//   trk  : rd_id_tracker_if.slave (issue, lookups, commit, busy, trace)
// Build option
//   RD_TRACKER_TRACE_EN : when defined, tr_rs_both_pending is a registered
//                         rs_inuse[0] & rs_inuse[1]; otherwise it is tied 0.
module rd_id_tracker
  import rd_id_tracker_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rd_id_tracker_if.slave trk
);

  rd_tracker_state_t             state;
  logic [4:0]                    clear_idx;
  id_t                           id_table [32];
  logic [31:0]                   pending;
  logic                          busy;
  logic                          issue_write;
  logic [REGFILE_READ_PORTS-1:0] rs_inuse;

  // Reset itself counts as busy so nothing is recorded while rst is high.
  assign busy        = rst | (state == RT_CLEAR);
  assign trk.busy    = busy;
  assign issue_write = trk.issue_valid & trk.issue_uses_rd &
                       rd_writable(trk.issue_rd_addr) & ~busy;

  // Lookups see the state before this cycle's issue/retire take effect.
  always_comb begin
    for (int j = 0; j < REGFILE_READ_PORTS; j++) begin
      rs_inuse[j]  = pending[trk.rs_addr[j]] & rd_writable(trk.rs_addr[j]) & ~busy;
      trk.rs_id[j] = id_table[trk.rs_addr[j]];
    end
    for (int i = 0; i < COMMIT_PORTS; i++) begin
      trk.id_for_rd[i] = id_table[trk.retired_rd_addr[i]];
    end
  end

  assign trk.rs_inuse = rs_inuse;

  // Clear-sweep FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RT_CLEAR;
      clear_idx <= 5'd0;
    end else begin
      case (state)
        RT_CLEAR: begin
          if (trk.gc_flush) begin
            clear_idx <= 5'd0;
          end else begin
            clear_idx <= clear_idx + 5'd1;
            if (clear_idx == 5'd31) state <= RT_IDLE;
          end
        end
        RT_IDLE: begin
          if (trk.gc_flush) begin
            state     <= RT_CLEAR;
            clear_idx <= 5'd0;
          end
        end
        default: state <= RT_CLEAR;
      endcase
    end
  end

  // Pending bits: later assignments win, so an issue to the same rd
  // overrides a retire clear in the same cycle. The sweep never overlaps
  // an issue because issue is gated by busy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < COMMIT_PORTS; i++) begin
      if (trk.retired[i] & rd_writable(trk.retired_rd_addr[i]) &
          (id_table[trk.retired_rd_addr[i]] == trk.ids_retiring[i])) begin
        pending[trk.retired_rd_addr[i]] <= 1'b0;
      end
    end
    if (state == RT_CLEAR) pending[clear_idx] <= 1'b0;
    if (issue_write) pending[trk.issue_rd_addr] <= 1'b1;
  end

  // Single-write ID table, no reset
  always_ff @(posedge clk) begin
    if (issue_write) id_table[trk.issue_rd_addr] <= trk.issue_id;
  end

`ifdef RD_TRACKER_TRACE_EN
  logic both_pending_p1;

  // Trace stage: one register after the lookup
  always_ff @(posedge clk) begin
    if (rst) both_pending_p1 <= 1'b0;
    else     both_pending_p1 <= rs_inuse[0] & rs_inuse[1];
  end

  assign trk.tr_rs_both_pending = both_pending_p1;
`else
  assign trk.tr_rs_both_pending = 1'b0;
`endif

endmodule

// File: tb/tb_rd_id_tracker.sv
module tb_rd_id_tracker;
  import rd_id_tracker_pkg::*;

  localparam int RP = REGFILE_READ_PORTS;
  localparam int CP = COMMIT_PORTS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rd_id_tracker_if trk ();

  rd_id_tracker dut (
    .clk (clk),
    .rst (rst),
    .trk (trk)
  );

  typedef struct {
    logic          busy;
    logic [RP-1:0] inuse;
    id_t  [RP-1:0] rs_id;
    logic [RP-1:0] rs_id_chk;
    id_t  [CP-1:0] ifr;
    logic [CP-1:0] ifr_chk;
    logic          tr;
    logic          tr_chk;
  } exp_t;

  exp_t q[$];

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: newest issued ID per register, outstanding flag,
  // and a countdown of remaining sweep cycles.
  int  newest [32];
  bit  known  [32];
  bit  pend   [32];
  int  sweep_left;
  bit  tr_m;
  bit  tr_known;

  // Stimulus for the next cycle
  bit         s_rst, s_flush, s_iv, s_iu;
  logic [4:0] s_ird;
  id_t        s_iid;
  logic [4:0] s_rs  [RP];
  bit         s_rt  [CP];
  logic [4:0] s_rrd [CP];
  id_t        s_rid [CP];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  task automatic idle_stim();
    s_rst = 0; s_flush = 0; s_iv = 0; s_iu = 0; s_ird = '0; s_iid = '0;
    for (int j = 0; j < RP; j++) s_rs[j] = '0;
    for (int i = 0; i < CP; i++) begin
      s_rt[i] = 0; s_rrd[i] = '0; s_rid[i] = '0;
    end
  endtask

  // Drive one cycle of stimulus, queue what the DUT should show during it,
  // then advance the model across the clock edge.
  task automatic step();
    exp_t          e;
    bit            bz;
    logic [RP-1:0] inuse_m;
    rst               = s_rst;
    trk.gc_flush      = s_flush;
    trk.issue_valid   = s_iv;
    trk.issue_uses_rd = s_iu;
    trk.issue_rd_addr = s_ird;
    trk.issue_id      = s_iid;
    for (int j = 0; j < RP; j++) trk.rs_addr[j] = s_rs[j];
    for (int i = 0; i < CP; i++) begin
      trk.retired[i]         = s_rt[i];
      trk.retired_rd_addr[i] = s_rrd[i];
      trk.ids_retiring[i]    = s_rid[i];
    end

    bz = s_rst || (sweep_left > 0);
    e.busy = bz;
    for (int j = 0; j < RP; j++) begin
      inuse_m[j]     = !bz && (s_rs[j] != 0) && pend[s_rs[j]];
      e.rs_id[j]     = id_t'(newest[s_rs[j]]);
      e.rs_id_chk[j] = inuse_m[j];
    end
    e.inuse = inuse_m;
    for (int i = 0; i < CP; i++) begin
      e.ifr[i]     = id_t'(newest[s_rrd[i]]);
      e.ifr_chk[i] = known[s_rrd[i]] && (s_rrd[i] != 0);
    end
`ifdef RD_TRACKER_TRACE_EN
    e.tr     = tr_m;
    e.tr_chk = tr_known;
`else
    e.tr     = 1'b0;
    e.tr_chk = 1'b1;
`endif
    q.push_back(e);

    for (int i = 0; i < CP; i++)
      if (s_rt[i] && s_rrd[i] != 0 && known[s_rrd[i]] && newest[s_rrd[i]] == int'(s_rid[i]))
        pend[s_rrd[i]] = 0;
    if (!bz && s_iv && s_iu && s_ird != 0) begin
      pend[s_ird]   = 1;
      newest[s_ird] = int'(s_iid);
      known[s_ird]  = 1;
    end
    if (s_rst) sweep_left = 32;
    else if (sweep_left > 0) begin
      pend[32 - sweep_left] = 0;
      sweep_left = s_flush ? 32 : sweep_left - 1;
    end else if (s_flush) sweep_left = 32;
    tr_m     = s_rst ? 1'b0 : (inuse_m[0] & inuse_m[1]);
    tr_known = 1;

    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the queued expectation each cycle
  exp_t mon_e;
  always begin
    @(negedge clk);
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("busy", 32'(trk.busy), 32'(mon_e.busy));
      for (int j = 0; j < RP; j++) begin
        chk($sformatf("rs_inuse[%0d]", j), 32'(trk.rs_inuse[j]), 32'(mon_e.inuse[j]));
        if (mon_e.rs_id_chk[j])
          chk($sformatf("rs_id[%0d]", j), 32'(trk.rs_id[j]), 32'(mon_e.rs_id[j]));
      end
      for (int i = 0; i < CP; i++)
        if (mon_e.ifr_chk[i])
          chk($sformatf("id_for_rd[%0d]", i), 32'(trk.id_for_rd[i]), 32'(mon_e.ifr[i]));
      if (mon_e.tr_chk)
        chk("tr_rs_both_pending", 32'(trk.tr_rs_both_pending), 32'(mon_e.tr));
    end
  end

  int cnt;
  int w;

  initial begin
    for (int r = 0; r < 32; r++) begin
      newest[r] = 0; known[r] = 0; pend[r] = 0;
    end
    sweep_left = 0; tr_m = 0; tr_known = 0;
    idle_stim();
    rst = 1'b1;
    trk.gc_flush = 0; trk.issue_valid = 0; trk.issue_uses_rd = 0;
    trk.issue_rd_addr = '0; trk.issue_id = '0; trk.rs_addr = '0;
    trk.retired = '0; trk.retired_rd_addr = '0; trk.ids_retiring = '0;
    @(posedge clk);
    #1;

    // Reset: one cycle of rst, then busy for exactly 32 cycles
    s_rst = 1; step(); s_rst = 0;
    cnt = 0;
    while (trk.busy === 1'b1 && cnt < 100) begin
      s_rs[0] = 5'(cnt); s_rs[1] = 5'(31 - cnt);
      step(); cnt++;
    end
    chk("busy_len_after_reset", cnt, 32);
    for (int r = 0; r < 32; r += 2) begin
      s_rs[0] = 5'(r); s_rs[1] = 5'(r + 1); step();
    end
    idle_stim();

    // Issue rd=5 id=3, look it up, retire it
    s_iv = 1; s_iu = 1; s_ird = 5; s_iid = 3; step(); idle_stim();
    s_rs[0] = 5; s_rrd[0] = 5; step();
    s_rs[0] = 5; s_rt[0] = 1; s_rrd[0] = 5; s_rid[0] = 3; step(); idle_stim();
    s_rs[0] = 5; step();

    // Two writers of rd=7; retiring the older leaves it pending
    s_iv = 1; s_iu = 1; s_ird = 7; s_iid = 1; step();
    s_ird = 7; s_iid = 2; step(); idle_stim();
    s_rt[1] = 1; s_rrd[1] = 7; s_rid[1] = 1; s_rs[1] = 7; step(); idle_stim();
    s_rs[0] = 7; s_rs[1] = 7; s_rrd[0] = 7; step();
    s_rt[0] = 1; s_rrd[0] = 7; s_rid[0] = 2; step(); idle_stim();
    s_rs[0] = 7; step();

    // Same-cycle issue and matching retire on rd=9: issue wins
    s_iv = 1; s_iu = 1; s_ird = 9; s_iid = 2; step();
    s_ird = 9; s_iid = 4; s_rt[0] = 1; s_rrd[0] = 9; s_rid[0] = 2; step(); idle_stim();
    s_rs[0] = 9; s_rs[1] = 5; s_rrd[0] = 9; step();

    // Writes to x0 are dropped
    s_iv = 1; s_iu = 1; s_ird = 0; s_iid = 6; step(); idle_stim();
    s_rs[0] = 0; s_rs[1] = 9; step();

    // Flush at clear_idx 10 restarts the sweep; issues while busy are ignored
    s_flush = 1; step(); idle_stim();
    repeat (10) step();
    s_flush = 1; step(); idle_stim();
    cnt = 0;
    while (trk.busy === 1'b1 && cnt < 100) begin
      s_iv = 1; s_iu = 1; s_ird = 12; s_iid = 5; s_rs[0] = 12;
      step(); cnt++;
    end
    chk("busy_len_after_flush", cnt, 32);
    idle_stim();
    s_rs[0] = 12; s_rs[1] = 9; step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      s_rst   = ($urandom_range(0, 999) == 0);
      s_flush = ($urandom_range(0, 149) == 0);
      s_iv    = ($urandom_range(0, 3) != 0);
      s_iu    = ($urandom_range(0, 4) != 0);
      s_ird   = 5'($urandom_range(0, 15));
      s_iid   = id_t'($urandom);
      for (int j = 0; j < RP; j++) s_rs[j] = 5'($urandom_range(0, 15));
      for (int i = 0; i < CP; i++) begin
        s_rt[i]  = ($urandom_range(0, 1) == 1);
        s_rrd[i] = 5'($urandom_range(0, 15));
        if (known[s_rrd[i]] && $urandom_range(0, 2) != 0) s_rid[i] = id_t'(newest[s_rrd[i]]);
        else s_rid[i] = id_t'($urandom);
      end
      step();
    end
    idle_stim();
    step();

    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    #1;
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
